// File: rtl/stg1if_if.sv
// PC/instruction interface of the fetch stage: instruction-memory port,
// downstream pipeline controls and the presented {pc, instr, valid} pair.
`timescale 1ns/1ps
interface stg1if_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
);
  logic              ow_imem_req;
  logic [ADDR_W-1:0] ow_imem_addr;
  logic              iw_imem_ack;
  logic              iw_imem_rvalid;
  logic [DATA_W-1:0] iw_imem_rdata;
  logic              iw_stall;
  logic              iw_redirect;
  logic [ADDR_W-1:0] iw_redirect_pc;
  logic [ADDR_W-1:0] ow_pc;
  logic [DATA_W-1:0] ow_instr;
  logic              ow_valid;

  modport master (
    output ow_imem_req, ow_imem_addr, ow_pc, ow_instr, ow_valid,
    input  iw_imem_ack, iw_imem_rvalid, iw_imem_rdata,
           iw_stall, iw_redirect, iw_redirect_pc
  );

  modport slave (
    input  ow_imem_req, ow_imem_addr, ow_pc, ow_instr, ow_valid,
    output iw_imem_ack, iw_imem_rvalid, iw_imem_rdata,
           iw_stall, iw_redirect, iw_redirect_pc
  );
endinterface

// File: rtl/stg1if.sv
// Instruction-fetch stage: single-outstanding imem reads, one-entry hold
// buffer for downstream stall, redirect with discard of in-flight responses.
`timescale 1ns/1ps
module stg1if #(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 24,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic     iw_clk,
  input  logic     iw_rst,
  stg1if_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] r_pc_q, r_pc_d;
  logic              discard_q, discard_d;
  fetch_t            hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  fetch_t            out_q, out_d;
  logic              out_vld_q, out_vld_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = r_pc_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    r_pc_d     = r_pc_q;
    discard_d  = discard_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;

    // An unstalled output register that is not reloaded drains to a bubble.
    if (!bus.iw_stall) begin
      out_vld_d   = 1'b0;
      out_d.instr = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (bus.iw_imem_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iw_imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (!bus.iw_stall) begin
            out_d     = '{pc: r_pc_q, instr: bus.iw_imem_rdata};
            out_vld_d = 1'b1;
            r_pc_d    = pc_inc;
            state_d   = S_REQ;
          end else begin
            hold_d     = '{pc: r_pc_q, instr: bus.iw_imem_rdata};
            hold_vld_d = 1'b1;
            r_pc_d     = pc_inc;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!bus.iw_stall) begin
          out_d      = hold_q;
          out_vld_d  = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything; a request already accepted for the old
    // PC must have its response swallowed.
    if (bus.iw_redirect) begin
      r_pc_d      = bus.iw_redirect_pc;
      out_vld_d   = 1'b0;
      out_d.pc    = out_q.pc;
      out_d.instr = NOP_INSTR;
      hold_vld_d  = 1'b0;
      case (state_q)
        S_REQ: begin
          state_d   = bus.iw_imem_ack ? S_WAIT : S_REQ;
          discard_d = bus.iw_imem_ack;
        end
        S_WAIT: begin
          state_d   = bus.iw_imem_rvalid ? S_REQ : S_WAIT;
          discard_d = !bus.iw_imem_rvalid;
        end
        default: begin
          state_d   = S_REQ;
          discard_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q    <= S_REQ;
      r_pc_q     <= RESET_PC;
      discard_q  <= 1'b0;
      hold_q     <= '{pc: '0, instr: NOP_INSTR};
      hold_vld_q <= 1'b0;
      out_q      <= '{pc: '0, instr: NOP_INSTR};
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_pc_q     <= r_pc_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.ow_imem_req  = (state_q == S_REQ) && !iw_rst;
  assign bus.ow_imem_addr = r_pc_q;
  assign bus.ow_pc        = out_q.pc;
  assign bus.ow_instr     = out_q.instr;
  assign bus.ow_valid     = out_vld_q;

endmodule

// File: tb/tb_stg1if.sv
// Bench for stg1if: cycle table of directed vectors, reset-in-hold sequence,
// then randomized memory/stall/redirect traffic against a stream model.
`timescale 1ns/1ps
module tb_stg1if;
  localparam logic [23:0] RPC = 24'h000010;
  localparam logic [23:0] KEY = 24'hA5A5A5;
  localparam logic [23:0] NOP = 24'h000013;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b1;
  always #5 iw_clk = ~iw_clk;

  stg1if_if #(.ADDR_W(24), .DATA_W(24)) bus ();

  stg1if #(.ADDR_W(24), .DATA_W(24), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .iw_clk(iw_clk),
    .iw_rst(iw_rst),
    .bus   (bus)
  );

  typedef struct {
    logic        ack, rv;
    logic [23:0] rdata;
    logic        stall, redir;
    logic [23:0] rpc;
    logic        req;
    logic [23:0] addr;
    logic        v;
    logic [23:0] pc, instr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic ack, logic rv, logic [23:0] rdata, logic stall,
                              logic redir, logic [23:0] rpc, logic req, logic [23:0] addr,
                              logic v, logic [23:0] pc, logic [23:0] instr);
    vec_t r;
    r.ack = ack; r.rv = rv; r.rdata = rdata; r.stall = stall; r.redir = redir;
    r.rpc = rpc; r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.instr = instr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic ack, logic rv, logic [23:0] rdata, logic stall,
                       logic redir, logic [23:0] rpc);
    bus.iw_imem_ack    = ack;
    bus.iw_imem_rvalid = rv;
    bus.iw_imem_rdata  = rdata;
    bus.iw_stall       = stall;
    bus.iw_redirect    = redir;
    bus.iw_redirect_pc = rpc;
  endtask

  // Called at a negedge: drive, take one rising edge, compare at the next negedge.
  task automatic apply(vec_t t, string tag);
    drive(t.ack, t.rv, t.rdata, t.stall, t.redir, t.rpc);
    @(posedge iw_clk);
    @(negedge iw_clk);
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
    chk({tag, ".req"},   32'(bus.ow_imem_req),  32'(t.req));
    chk({tag, ".addr"},  32'(bus.ow_imem_addr), 32'(t.addr));
    chk({tag, ".valid"}, 32'(bus.ow_valid),     32'(t.v));
    chk({tag, ".pc"},    32'(bus.ow_pc),        32'(t.pc));
    chk({tag, ".instr"}, 32'(bus.ow_instr),     32'(t.instr));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_pc, prev_pc, prev_instr, prev_rpc, mem_addr, rpc, junk;
    logic        prev_v, prev_stall, prev_redir, stall, redir, ack, rv;
    logic        mem_busy;
    int          mem_cnt, ack_wait, n_pres;

    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
    repeat (3) @(negedge iw_clk);
    chk("rst.req",   32'(bus.ow_imem_req),  32'd0);
    chk("rst.addr",  32'(bus.ow_imem_addr), 32'(RPC));
    chk("rst.valid", 32'(bus.ow_valid),     32'd0);
    chk("rst.pc",    32'(bus.ow_pc),        32'd0);
    chk("rst.instr", 32'(bus.ow_instr),     32'(NOP));
    iw_rst = 1'b0;
    #1;
    chk("rel.req", 32'(bus.ow_imem_req), 32'd1);
    @(negedge iw_clk);

    // ack, rv, rdata, stall, redir, rpc | req, addr, valid, pc, instr
    tbl.push_back(mk(1,0,24'h0,       0,0,24'h0,      0,24'h10,    0,24'h0,     NOP));
    tbl.push_back(mk(0,1,24'h10^KEY,  0,0,24'h0,      1,24'h11,    1,24'h10,    24'h10^KEY));
    tbl.push_back(mk(1,0,24'h0,       0,0,24'h0,      0,24'h11,    0,24'h10,    NOP));
    tbl.push_back(mk(0,1,24'h11^KEY,  1,0,24'h0,      0,24'h12,    0,24'h10,    NOP));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,24'h0,     1,0,24'h0,      0,24'h12,    0,24'h10,    NOP));
    tbl.push_back(mk(0,0,24'h0,       0,0,24'h0,      1,24'h12,    1,24'h11,    24'h11^KEY));
    tbl.push_back(mk(1,0,24'h0,       1,0,24'h0,      0,24'h12,    1,24'h11,    24'h11^KEY));
    tbl.push_back(mk(0,0,24'h0,       1,1,24'hFFFFFF, 0,24'hFFFFFF,0,24'h11,    NOP));
    tbl.push_back(mk(0,1,24'h123456,  0,0,24'h0,      1,24'hFFFFFF,0,24'h11,    NOP));
    tbl.push_back(mk(0,0,24'h0,       0,0,24'h0,      1,24'hFFFFFF,0,24'h11,    NOP));
    tbl.push_back(mk(1,0,24'h0,       0,0,24'h0,      0,24'hFFFFFF,0,24'h11,    NOP));
    tbl.push_back(mk(0,1,24'hFFFFFF^KEY,0,0,24'h0,    1,24'h0,     1,24'hFFFFFF,24'hFFFFFF^KEY));
    tbl.push_back(mk(1,0,24'h0,       0,1,24'h200,    0,24'h200,   0,24'hFFFFFF,NOP));
    tbl.push_back(mk(0,1,24'h0^KEY,   0,0,24'h0,      1,24'h200,   0,24'hFFFFFF,NOP));
    tbl.push_back(mk(1,0,24'h0,       0,0,24'h0,      0,24'h200,   0,24'hFFFFFF,NOP));
    tbl.push_back(mk(0,1,24'h200^KEY, 0,1,24'h300,    1,24'h300,   0,24'hFFFFFF,NOP));
    tbl.push_back(mk(1,0,24'h0,       0,0,24'h0,      0,24'h300,   0,24'hFFFFFF,NOP));
    tbl.push_back(mk(0,1,24'h300^KEY, 0,0,24'h0,      1,24'h301,   1,24'h300,   24'h300^KEY));
    tbl.push_back(mk(0,1,24'hABCDEF,  0,0,24'h0,      1,24'h301,   0,24'h300,   NOP));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reach S_HOLD with a valid word on the outputs, then reset mid-cycle.
    apply(mk(1,0,24'h0,       0,0,24'h0, 0,24'h301,0,24'h300,NOP),         "hold.a");
    apply(mk(0,1,24'h301^KEY, 0,0,24'h0, 1,24'h302,1,24'h301,24'h301^KEY), "hold.b");
    apply(mk(1,0,24'h0,       1,0,24'h0, 0,24'h302,1,24'h301,24'h301^KEY), "hold.c");
    apply(mk(0,1,24'h302^KEY, 1,0,24'h0, 0,24'h303,1,24'h301,24'h301^KEY), "hold.d");
    bus.iw_stall = 1'b1;
    #2 iw_rst = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.ow_valid),     32'd0);
    chk("arst.pc",    32'(bus.ow_pc),        32'd0);
    chk("arst.instr", 32'(bus.ow_instr),     32'(NOP));
    chk("arst.req",   32'(bus.ow_imem_req),  32'd0);
    chk("arst.addr",  32'(bus.ow_imem_addr), 32'(RPC));
    @(negedge iw_clk);
    iw_rst = 1'b0;
    drive(1'b0, 1'b1, 24'h777777, 1'b0, 1'b0, 24'h0);
    @(posedge iw_clk);
    @(negedge iw_clk);
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
    chk("late_rv.req",   32'(bus.ow_imem_req),  32'd1);
    chk("late_rv.addr",  32'(bus.ow_imem_addr), 32'(RPC));
    chk("late_rv.valid", 32'(bus.ow_valid),     32'd0);

    // Random phase: the model only knows the presented stream must be
    // contiguous from the last redirect target with data = addr ^ KEY.
    iw_rst = 1'b1;
    @(negedge iw_clk);
    iw_rst = 1'b0;
    exp_pc = RPC; prev_v = 1'b0; prev_pc = 24'h0; prev_instr = NOP;
    prev_stall = 1'b0; prev_redir = 1'b0; prev_rpc = 24'h0;
    mem_busy = 1'b0; mem_cnt = 0; ack_wait = -1; n_pres = 0; mem_addr = 24'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge iw_clk);
      if (prev_redir) begin
        chk("rnd.redir_valid", 32'(bus.ow_valid), 32'd0);
        chk("rnd.redir_instr", 32'(bus.ow_instr), 32'(NOP));
        exp_pc = prev_rpc;
      end else if (prev_stall) begin
        chk("rnd.stall_valid", 32'(bus.ow_valid), 32'(prev_v));
        chk("rnd.stall_pc",    32'(bus.ow_pc),    32'(prev_pc));
        chk("rnd.stall_instr", 32'(bus.ow_instr), 32'(prev_instr));
      end else if (bus.ow_valid) begin
        chk("rnd.pc",    32'(bus.ow_pc),    32'(exp_pc));
        chk("rnd.instr", 32'(bus.ow_instr), 32'(exp_pc ^ KEY));
        exp_pc = exp_pc + 24'd1;
        n_pres++;
      end else begin
        chk("rnd.bubble_instr", 32'(bus.ow_instr), 32'(NOP));
        chk("rnd.bubble_pc",    32'(bus.ow_pc),    32'(prev_pc));
      end
      prev_v = bus.ow_valid; prev_pc = bus.ow_pc; prev_instr = bus.ow_instr;

      chk("rnd.one_outstanding", 32'(bus.ow_imem_req && mem_busy), 32'd0);
      ack = 1'b0; rv = 1'b0; junk = 24'($urandom);
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          rv = 1'b1; junk = mem_addr ^ KEY; mem_busy = 1'b0;
        end else mem_cnt--;
      end else if (bus.ow_imem_req) begin
        if (ack_wait < 0) ack_wait = $urandom_range(0, 3);
        if (ack_wait == 0) begin
          ack = 1'b1; mem_addr = bus.ow_imem_addr; mem_busy = 1'b1;
          mem_cnt = $urandom_range(0, 3); ack_wait = -1;
        end else ack_wait--;
      end

      stall = ($urandom_range(0, 99) < 30);
      redir = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) rpc = 24'hFFFFFE + 24'($urandom_range(0, 1));
      else rpc = 24'($urandom);
      drive(ack, rv, junk, stall, redir, rpc);
      prev_stall = stall; prev_redir = redir; prev_rpc = rpc;
    end
    chk("rnd.progress", 32'(n_pres > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
